but_led_debounce: RTL

Parametrised successor to the direct button-to-LED register stage. It takes CHANNELS active-low push-buttons and synchronises each one into CLK. It debounces each button with a per-channel counter and drives one LED per channel in either follow mode or toggle mode. It also exports the debounced level and a one-cycle press pulse per channel for other logic on the 100 MHz board clock.

---
 rtl/but_led_debounce.sv | 115 +++++++++++
 1 files changed

// File: rtl/but_led_debounce.sv
// Per-channel button synchroniser, debouncer and LED driver (follow or toggle mode).
// Optional long-press strobe compiled in with `define BUT_LED_LONG_PRESS_EN.
module but_led_debounce #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TOGGLE_MODE     = 0,
  parameter int HOLD_CYCLES     = 200000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] BUT,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] PRESSED,
  output logic [CHANNELS-1:0] PRESS_PULSE,
  output logic [CHANNELS-1:0] LONG_PULSE
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("but_led_debounce: CHANNELS, DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] samp;
  logic [CHANNELS-1:0] pressed_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] long_hit;
  logic [CHANNELS-1:0] long_sat;
  logic [CW-1:0]       cnt [CHANNELS];

  assign samp = ~sync2;
  assign rise = PRESSED & ~pressed_d;

  // Reset value 1 on the synchroniser reads as "released" until real samples arrive.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1   <= '1;
      sync2   <= '1;
      PRESSED <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
    end else begin
      sync1 <= BUT;
      sync2 <= sync1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (samp[c] == PRESSED[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_LAST) begin
          PRESSED[c] <= samp[c];
          cnt[c]     <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pressed_d   <= '0;
      PRESS_PULSE <= '0;
      LED         <= '0;
    end else begin
      pressed_d   <= PRESSED;
      PRESS_PULSE <= rise;
      for (int c = 0; c < CHANNELS; c++) begin
        if (TOGGLE_MODE != 0) begin
          if (long_hit[c])  LED[c] <= 1'b0;
          else if (rise[c]) LED[c] <= ~LED[c];
        end else begin
          // A long press keeps the LED dark until the button is released and pressed again.
          LED[c] <= PRESSED[c] & ~long_sat[c];
        end
      end
    end
  end

`ifdef BUT_LED_LONG_PRESS_EN
  localparam int            HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt [CHANNELS];

  always_comb begin
    long_hit = '0;
    long_sat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      long_hit[c] = PRESSED[c] && (hold_cnt[c] == HOLD_LAST);
      long_sat[c] = PRESSED[c] && (hold_cnt[c] >= HOLD_LAST);
    end
  end

  // Saturating at HOLD_MAX gives exactly one strobe per press.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LONG_PULSE <= '0;
      for (int c = 0; c < CHANNELS; c++) hold_cnt[c] <= '0;
    end else begin
      LONG_PULSE <= long_hit;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!PRESSED[c])                 hold_cnt[c] <= '0;
        else if (hold_cnt[c] != HOLD_MAX) hold_cnt[c] <= hold_cnt[c] + 1'b1;
      end
    end
  end
`else
  assign long_hit   = '0;
  assign long_sat   = '0;
  assign LONG_PULSE = '0;
`endif

endmodule
